// File: rtl/mem_req_arbiter_pkg.sv
// Shared constants for the memory request arbiter: requester IDs and size encodings.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mem_req_arbiter_pkg;

  // Owner ID stored in the ordering FIFO for every accepted request.
  localparam logic REQ_ID_INST = 1'b0;
  localparam logic REQ_ID_DATA = 1'b1;

  // Access size encodings carried on *_size.
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/req_order_fifo.sv
// Ordering FIFO: remembers which requester owns each outstanding memory request.
// Latency: push visible at head one cycle later; head/full/empty come straight from registers.
// Backpressure: full_o is the producer's stall; a pop in the same cycle does not free a slot.
//
// Ports: clk, reset (sync, active-high); push_i/push_id_i write an owner ID;
//        pop_i drops the head; head_o, full_o, empty_o describe the current state.
module req_order_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push_i,
  input  logic push_id_i,
  input  logic pop_i,
  output logic head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] id_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             push_en, pop_en;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = id_q[rd_ptr_q];

  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (reset) begin
      id_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_en) begin
        id_q[wr_ptr_q] <= push_id_i;
        wr_ptr_q       <= ptr_inc(wr_ptr_q);
      end
      if (pop_en) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push_en, pop_en})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one SRAM-like req/addr_ok/data_ok port between the inst and data requesters, in-order responses.
// Latency: zero added cycles; request mux and response routing are purely combinational.
// Backpressure: mem_req drops while MAX_OUTSTANDING requests await data_ok; grant held while addr_ok is low.
//
// Ports: clk, reset (sync, active-high); inst_* / data_* requester ports (req, wr, size, addr,
//        wstrb, wdata in; addr_ok, data_ok, rdata out); mem_* shared port toward the bus bridge.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

  logic            lock_q, lock_d;
  logic            sel_q, sel_d;
  logic [SC_W-1:0] starve_q, starve_d;
  logic            err_q, err_d;

  logic grant;
  logic sel_req;
  logic handshake;
  logic fifo_full, fifo_empty, fifo_head;
  logic resp_vld;

  // Grant: a locked handshake keeps its owner; otherwise data wins unless inst has been starved.
  always_comb begin
    grant = REQ_ID_DATA;
    if (lock_q) begin
      grant = sel_q;
    end else if (inst_req && (starve_q == STARVE_MAX)) begin
      grant = REQ_ID_INST;
    end else if (data_req) begin
      grant = REQ_ID_DATA;
    end else if (inst_req) begin
      grant = REQ_ID_INST;
    end
  end

  assign sel_req = (sel_q == REQ_ID_DATA) ? data_req : inst_req;
  assign mem_req = (lock_q ? sel_req : (inst_req | data_req)) & ~fifo_full;

  assign mem_wr    = (grant == REQ_ID_DATA) ? data_wr    : inst_wr;
  assign mem_size  = (grant == REQ_ID_DATA) ? data_size  : inst_size;
  assign mem_addr  = (grant == REQ_ID_DATA) ? data_addr  : inst_addr;
  assign mem_wstrb = (grant == REQ_ID_DATA) ? data_wstrb : inst_wstrb;
  assign mem_wdata = (grant == REQ_ID_DATA) ? data_wdata : inst_wdata;

  assign handshake    = mem_req & mem_addr_ok;
  assign inst_addr_ok = handshake & (grant == REQ_ID_INST);
  assign data_addr_ok = handshake & (grant == REQ_ID_DATA);

  // A data_ok with nothing outstanding is dropped rather than misrouted.
  assign resp_vld     = mem_data_ok & ~fifo_empty;
  assign inst_data_ok = resp_vld & (fifo_head == REQ_ID_INST);
  assign data_data_ok = resp_vld & (fifo_head == REQ_ID_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  always_comb begin
    lock_d   = lock_q;
    sel_d    = sel_q;
    starve_d = starve_q;
    err_d    = err_q | (mem_data_ok & fifo_empty);

    // An offered but unaccepted request pins the grant until the handshake.
    if (mem_req) begin
      sel_d  = grant;
      lock_d = ~mem_addr_ok;
    end

    if (!inst_req || inst_addr_ok) begin
      starve_d = '0;
    end else if (data_addr_ok && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q   <= 1'b0;
      sel_q    <= REQ_ID_DATA;
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      lock_q   <= lock_d;
      sel_q    <= sel_d;
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

  req_order_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_order_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (handshake),
    .push_id_i (grant),
    .pop_i     (mem_data_ok),
    .head_o    (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

endmodule

// File: tb/tb_mem_req_arbiter.sv
module tb_mem_req_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic [3:0]  inst_wstrb;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_req_arbiter #(
    .MAX_OUTSTANDING (2),
    .STARVE_LIMIT    (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_addr    (inst_addr),
    .inst_wstrb   (inst_wstrb),
    .inst_wdata   (inst_wdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wstrb   (data_wstrb),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_size     (mem_size),
    .mem_addr     (mem_addr),
    .mem_wstrb    (mem_wstrb),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Move to the next negedge and clear every stimulus input.
  task automatic next_cycle();
    @(negedge clk);
    reset       = 1'b0;
    inst_req    = 1'b0; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = '0;
    inst_wstrb  = 4'hf; inst_wdata = '0;
    data_req    = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_addr = '0;
    data_wstrb  = 4'hf; data_wdata = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #1;
  endtask

  logic       prev_hs;
  logic [9:0] exp_grant_data = 10'b0111101111; // bit i: cycle i granted to DATA

  initial begin
    next_cycle();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    next_cycle();
    settle();
    check("rst_mem_req",      mem_req,      0);
    check("rst_inst_addr_ok", inst_addr_ok, 0);
    check("rst_data_addr_ok", data_addr_ok, 0);
    check("rst_inst_data_ok", inst_data_ok, 0);
    check("rst_data_data_ok", data_data_ok, 0);
    check("rst_err",          dut.err_q,    0);

    // Data-only load: accept in cycle 0, response in cycle 2.
    next_cycle();
    data_req = 1'b1; data_addr = 32'h1c000100; mem_addr_ok = 1'b1;
    settle();
    check("ld_mem_req",      mem_req,      1);
    check("ld_mem_addr",     mem_addr,     32'h1c000100);
    check("ld_data_addr_ok", data_addr_ok, 1);
    check("ld_inst_addr_ok", inst_addr_ok, 0);
    next_cycle();
    settle();
    check("ld_c1_data_ok",   data_data_ok, 0);
    next_cycle();
    mem_data_ok = 1'b1; mem_rdata = 32'hdeadbeef;
    settle();
    check("ld_data_data_ok", data_data_ok, 1);
    check("ld_data_rdata",   data_rdata,   32'hdeadbeef);
    check("ld_inst_data_ok", inst_data_ok, 0);

    // Contention: data first, inst second; responses return in that order.
    next_cycle();
    inst_req = 1'b1; inst_addr = 32'h00001000;
    data_req = 1'b1; data_addr = 32'h00002000; mem_addr_ok = 1'b1;
    settle();
    check("ct_addr0",      mem_addr,     32'h00002000);
    check("ct_data_aok",   data_addr_ok, 1);
    check("ct_inst_aok0",  inst_addr_ok, 0);
    next_cycle();
    inst_req = 1'b1; inst_addr = 32'h00001000; mem_addr_ok = 1'b1;
    settle();
    check("ct_addr1",      mem_addr,     32'h00001000);
    check("ct_inst_aok1",  inst_addr_ok, 1);
    next_cycle();
    mem_data_ok = 1'b1; mem_rdata = 32'h11111111;
    settle();
    check("ct_resp0_data", data_data_ok, 1);
    check("ct_resp0_inst", inst_data_ok, 0);
    next_cycle();
    mem_data_ok = 1'b1; mem_rdata = 32'h22222222;
    settle();
    check("ct_resp1_inst", inst_data_ok, 1);
    check("ct_resp1_data", data_data_ok, 0);
    check("ct_inst_rdata", inst_rdata,   32'h22222222);

    // Lock: inst offered with addr_ok low for 3 cycles, data rises meanwhile.
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      inst_req = 1'b1; inst_addr = 32'h00003000;
      if (c > 0) begin
        data_req = 1'b1; data_addr = 32'h00004000;
      end
      settle();
      check("lk_hold_addr", mem_addr,     32'h00003000);
      check("lk_hold_req",  mem_req,      1);
      check("lk_no_dgrant", data_addr_ok, 0);
    end
    next_cycle();
    inst_req = 1'b1; inst_addr = 32'h00003000;
    data_req = 1'b1; data_addr = 32'h00004000; mem_addr_ok = 1'b1;
    settle();
    check("lk_hs_addr",    mem_addr,     32'h00003000);
    check("lk_inst_aok",   inst_addr_ok, 1);
    check("lk_data_aok0",  data_addr_ok, 0);
    next_cycle();
    data_req = 1'b1; data_addr = 32'h00004000; mem_addr_ok = 1'b1;
    settle();
    check("lk_next_addr",  mem_addr,     32'h00004000);
    check("lk_data_aok1",  data_addr_ok, 1);
    next_cycle();
    mem_data_ok = 1'b1;
    settle();
    check("lk_resp_inst",  inst_data_ok, 1);
    next_cycle();
    mem_data_ok = 1'b1;
    settle();
    check("lk_resp_data",  data_data_ok, 1);

    // Full: two accepted, third cycle blocked; a pop frees the slot one cycle later.
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      data_req = 1'b1; data_addr = 32'h00005000; mem_addr_ok = 1'b1;
      settle();
      check("fl_fill_aok", data_addr_ok, 1);
    end
    next_cycle();
    data_req = 1'b1; data_addr = 32'h00005000; mem_addr_ok = 1'b1;
    settle();
    check("fl_full_req",   mem_req,      0);
    check("fl_full_aok",   data_addr_ok, 0);
    next_cycle();
    data_req = 1'b1; data_addr = 32'h00005000; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    settle();
    check("fl_pop_req",    mem_req,      0);
    check("fl_pop_dok",    data_data_ok, 1);
    next_cycle();
    data_req = 1'b1; data_addr = 32'h00005000; mem_addr_ok = 1'b1;
    settle();
    check("fl_after_req",  mem_req,      1);
    check("fl_after_aok",  data_addr_ok, 1);
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      mem_data_ok = 1'b1;
      settle();
      check("fl_drain_dok", data_data_ok, 1);
    end

    // Starvation: both requesting, instant addr_ok, data_ok one cycle after each accept.
    prev_hs = 1'b0;
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      inst_req = 1'b1; inst_addr = 32'h00006000;
      data_req = 1'b1; data_addr = 32'h00007000;
      mem_addr_ok = 1'b1; mem_data_ok = prev_hs;
      settle();
      check($sformatf("sv_grant_data%0d", c), data_addr_ok, exp_grant_data[c]);
      check($sformatf("sv_grant_inst%0d", c), inst_addr_ok, !exp_grant_data[c]);
      prev_hs = inst_addr_ok | data_addr_ok;
    end
    next_cycle();
    mem_data_ok = 1'b1;
    settle();
    check("sv_last_resp_inst", inst_data_ok, 1);

    // Protocol error: data_ok with nothing outstanding.
    next_cycle();
    mem_data_ok = 1'b1; mem_rdata = 32'h0badf00d;
    settle();
    check("pe_inst_dok", inst_data_ok, 0);
    check("pe_data_dok", data_data_ok, 0);
    next_cycle();
    settle();
    check("pe_err",      dut.err_q,    1);

    // Reset mid-transaction clears the outstanding entry.
    next_cycle();
    data_req = 1'b1; data_addr = 32'h00008000; mem_addr_ok = 1'b1;
    settle();
    check("rm_push_aok", data_addr_ok, 1);
    next_cycle();
    reset = 1'b1;
    @(posedge clk);
    next_cycle();
    settle();
    check("rm_err_clr",  dut.err_q,    0);
    mem_data_ok = 1'b1;
    settle();
    check("rm_no_dok",   data_data_ok, 0);

    next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares one SRAM-like memory port between the IF instruction-fetch requester and the EX/ME data requester.
- Interface is req / addr_ok / data_ok, with multiple requests in flight and responses returned in order.
- Sits between the pipeline's inst/data request ports and the future AXI bridge.
- Tracks request ownership in an ordering FIFO so each data_ok and rdata goes back to the requester that issued it.

Parameters:
- MAX_OUTSTANDING, 2: accepted requests allowed without data_ok (1..4).
- STARVE_LIMIT, 4: consecutive data grants, while inst_req is pending, before inst is forced one grant.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- inst_req  in  1  instruction request valid
- inst_wr  in  1  write flag (always 0 from IF, passed through)
- inst_size  in  2  0=byte, 1=half, 2=word
- inst_addr  in  32  request address
- inst_wstrb  in  4  byte strobes
- inst_wdata  in  32  write data
- inst_addr_ok  out  1  inst request accepted this cycle
- inst_data_ok  out  1  inst response this cycle
- inst_rdata  out  32  inst read data
- data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata  in  1/1/2/32/4/32  data-side request, same meaning as inst_*
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  data response this cycle
- data_rdata  out  32  data read data
- mem_req  out  1  shared request valid
- mem_wr  out  1  shared write flag
- mem_size  out  2  shared size
- mem_addr  out  32  shared address
- mem_wstrb  out  4  shared strobes
- mem_wdata  out  32  shared write data
- mem_addr_ok  in  1  shared request accepted
- mem_data_ok  in  1  shared response valid
- mem_rdata  in  32  shared read data

Behaviour:
- Reset:
  - lock=0, sel=DATA, starve_cnt=0, FIFO empty.
  - mem_req=0, all *_addr_ok and *_data_ok = 0.
  - rdata outputs are don't-care.
- Grant, when unlocked:
  - Data has priority over inst.
  - Inst wins if starve_cnt==STARVE_LIMIT and inst_req=1.
- Lock:
  - If mem_req=1 and mem_addr_ok=0, set lock=1 and hold sel.
  - While locked, mem_* is driven from the selected requester.
  - The requester must hold its request stable; the arbiter never switches grant mid-handshake.
  - Lock clears on the handshake cycle.
- Request output:
  - mem_req = (inst_req|data_req) & !fifo_full.
  - When locked, mem_req = sel_req & !fifo_full.
  - mem_* fields are muxed combinationally from the granted side.
  - Zero added latency.
- Address accept:
  - x_addr_ok = mem_addr_ok & mem_req & (grant==x).
  - On a handshake, push the owner ID (0=INST, 1=DATA) into the ordering FIFO (depth MAX_OUTSTANDING).
- Response routing:
  - On mem_data_ok, pop the FIFO head and route: head==INST gives inst_data_ok=1 and inst_rdata=mem_rdata; otherwise data_data_ok=1 and data_rdata=mem_rdata.
  - Combinational, same cycle as mem_data_ok.
- Full: FIFO holds MAX_OUTSTANDING entries → mem_req=0 and no grant.
  - Same-cycle pop does not free a slot for a push (registered full).
- Simultaneous push and pop: both are performed and the count is unchanged.
  - The pointers wrap modulo MAX_OUTSTANDING.
- Empty FIFO with mem_data_ok=1: protocol error.
  - The response is dropped; both data_ok outputs stay 0.
  - Sticky internal err flag, visible to the bench hierarchically.
- Starvation counter:
  - Increments on each data handshake while inst_req=1, saturating at STARVE_LIMIT.
  - Clears on an inst handshake or when inst_req=0.
- Flush policy: no flush input.
  - Responses to requests already accepted are always delivered to their owner; IF/EX discard stale data themselves.
- Reset mid-transaction: FIFO and lock are cleared.
  - The memory side is reset by the same signal, so no late data_ok is expected.

Decomposition:
- Shared package/header (my_cpu.vh): constants REQ_ID_INST=1'b0, REQ_ID_DATA=1'b1, and SIZE_BYTE/HALF/WORD encodings.
- One sub-module, req_order_fifo: a 1-bit-wide, MAX_OUTSTANDING-deep FIFO with push, pop, head, full and empty.

Test Plan:
- Data-only load:
  - Stimulus: data_req=1, addr=0x1c000100, mem_addr_ok in the same cycle, mem_data_ok 2 cycles later with rdata=0xdeadbeef.
  - Required: data_addr_ok=1 in cycle 0; data_data_ok=1 with data_rdata=0xdeadbeef in cycle 2; inst_data_ok stays 0.
- Contention:
  - Stimulus: inst_req and data_req both 1 in the same cycle.
  - Required: mem_addr = data_addr in the first grant and inst second; responses deliver first to DATA, then to INST.
- Lock:
  - Stimulus: inst granted with mem_addr_ok held 0 for 3 cycles, and data_req rises in cycle 1.
  - Required: mem_addr stays = inst_addr until the handshake; data is granted next.
- Full:
  - Stimulus: MAX_OUTSTANDING=2, two accepted requests with no data_ok.
  - Required: mem_req=0 in the third cycle; after one mem_data_ok, mem_req=1 the next cycle.
- Starvation:
  - Stimulus: data_req and inst_req held 1 continuously, instant addr_ok.
  - Required: grants are D,D,D,D,I,D….
- Protocol error:
  - Stimulus: mem_data_ok=1 with the FIFO empty.
  - Required: no data_ok output asserts; err=1.
